// File: rtl/register_block_mw_if.sv
// register_block_mw_if: write, dual-read and clear-control bundle for the warp register block.
interface register_block_mw_if #(
  parameter int LANES = 16,
  parameter int REGS  = 64,
  parameter int WIDTH = 32,
  parameter int WARPS = 8
);
  localparam int AW = $clog2(REGS);
  localparam int WW = $clog2(WARPS);
  logic [LANES-1:0]       write_en;
  logic [WW-1:0]          wwarp;
  logic [AW-1:0]          waddr;
  logic [LANES*WIDTH-1:0] wdata;
  logic [LANES-1:0]       read_en_0;
  logic [WW-1:0]          rwarp_0;
  logic [AW-1:0]          raddr_0;
  logic [LANES-1:0]       read_en_1;
  logic [WW-1:0]          rwarp_1;
  logic [AW-1:0]          raddr_1;
  logic [LANES*WIDTH-1:0] rdata_0;
  logic [LANES*WIDTH-1:0] rdata_1;
  logic                   clr_req;
  logic [WW-1:0]          clr_warp;
  logic                   clr_busy;
  logic                   clr_done;
  logic                   wr_reject;
  modport master (
    output write_en, wwarp, waddr, wdata, read_en_0, rwarp_0, raddr_0,
           read_en_1, rwarp_1, raddr_1, clr_req, clr_warp,
    input  rdata_0, rdata_1, clr_busy, clr_done, wr_reject
  );
  modport slave (
    input  write_en, wwarp, waddr, wdata, read_en_0, rwarp_0, raddr_0,
           read_en_1, rwarp_1, raddr_1, clr_req, clr_warp,
    output rdata_0, rdata_1, clr_busy, clr_done, wr_reject
  );
endinterface

// File: rtl/register_block_mw.sv
// register_block_mw: banked WARPS x REGS x LANES register file, 2 read / 1 masked write, background warp clear.
// Optional RBLOCK_BYPASS_EN: same-cycle reads see the accepted write data (or 0 from the clear engine).
module register_block_mw #(
  parameter int LANES = 16,
  parameter int REGS  = 64,
  parameter int WIDTH = 32,
  parameter int WARPS = 8
) (
  input logic clk,
  input logic rst,
  register_block_mw_if.slave bus
);
  localparam int AW = $clog2(REGS);
  localparam int WW = $clog2(WARPS);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t                 state_q;
  logic [AW:0]            ptr_q;
  logic [WW-1:0]          cwarp_q;
  logic                   clr_busy_q;
  logic                   clr_done_q;
  logic                   wr_reject_q;
  logic [WIDTH-1:0]       mem_q [WARPS][REGS][LANES];
  logic [LANES*WIDTH-1:0] rd_q [2];
  logic [LANES*WIDTH-1:0] rd_d [2];
  logic [LANES-1:0]       ren [2];
  logic [WW-1:0]          rw [2];
  logic [AW-1:0]          ra [2];
  logic [1:0]             rd_ok;
  logic [WIDTH-1:0]       lane;
  logic                   reject;
  logic                   wr_acc;
  logic                   clr_act;
  assign ren[0] = bus.read_en_0;
  assign ren[1] = bus.read_en_1;
  assign rw[0]  = bus.rwarp_0;
  assign rw[1]  = bus.rwarp_1;
  assign ra[0]  = bus.raddr_0;
  assign ra[1]  = bus.raddr_1;
  assign rd_ok[0] = ({1'b0, ra[0]} < (AW+1)'(REGS)) && ({1'b0, rw[0]} < (WW+1)'(WARPS));
  assign rd_ok[1] = ({1'b0, ra[1]} < (AW+1)'(REGS)) && ({1'b0, rw[1]} < (WW+1)'(WARPS));
  assign reject  = (state_q == CLEAR) && |bus.write_en && (bus.wwarp == cwarp_q);
  assign wr_acc  = !rst && !reject && |bus.write_en &&
                   ({1'b0, bus.waddr} < (AW+1)'(REGS)) && ({1'b0, bus.wwarp} < (WW+1)'(WARPS));
  assign clr_act = !rst && (state_q == CLEAR);
  assign bus.rdata_0   = rd_q[0];
  assign bus.rdata_1   = rd_q[1];
  assign bus.clr_busy  = clr_busy_q;
  assign bus.clr_done  = clr_done_q;
  assign bus.wr_reject = wr_reject_q;
  // Storage is never reset; only accepted writes and the clear engine touch it.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr_acc && bus.write_en[l]) mem_q[bus.wwarp][bus.waddr][l] <= bus.wdata[l*WIDTH +: WIDTH];
      if (clr_act) mem_q[cwarp_q][ptr_q[AW-1:0]][l] <= '0;
    end
  end
  always_comb begin
    lane = '0;
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = rd_q[p];
      for (int l = 0; l < LANES; l++) begin
`ifdef RBLOCK_BYPASS_EN
        lane = (wr_acc && bus.write_en[l] && rw[p] == bus.wwarp && ra[p] == bus.waddr) ? bus.wdata[l*WIDTH +: WIDTH] :
               (clr_act && rw[p] == cwarp_q && ra[p] == ptr_q[AW-1:0]) ? '0 : mem_q[rw[p]][ra[p]][l];
`else
        lane = mem_q[rw[p]][ra[p]][l];
`endif
        if (ren[p][l]) rd_d[p][l*WIDTH +: WIDTH] = rd_ok[p] ? lane : '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cwarp_q     <= '0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      wr_reject_q <= 1'b0;
      rd_q[0]     <= '0;
      rd_q[1]     <= '0;
    end else begin
      rd_q[0]     <= rd_d[0];
      rd_q[1]     <= rd_d[1];
      wr_reject_q <= reject;
      clr_done_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.clr_req) begin
          cwarp_q    <= bus.clr_warp;
          ptr_q      <= '0;
          state_q    <= CLEAR;
          clr_busy_q <= 1'b1;
        end
        CLEAR: begin
          ptr_q <= ptr_q + (AW+1)'(1);
          if (ptr_q == (AW+1)'(REGS-1)) begin
            state_q    <= DONE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_block_mw.sv
// tb_register_block_mw: directed self-checking bench for register_block_mw.
module tb_register_block_mw;
  localparam int LANES = 16, REGS = 64, WIDTH = 32, WARPS = 8, AW = 6, WW = 3;
  localparam int VW = LANES * WIDTH;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  register_block_mw_if #(.LANES(LANES), .REGS(REGS), .WIDTH(WIDTH), .WARPS(WARPS)) bus();
  register_block_mw #(.LANES(LANES), .REGS(REGS), .WIDTH(WIDTH), .WARPS(WARPS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] vec(input logic [WIDTH-1:0] base, input bit inc);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = base + (inc ? WIDTH'(i) : '0);
    return v;
  endfunction

  task automatic idle;
    bus.write_en = '0; bus.wwarp = '0; bus.waddr = '0; bus.wdata = '0;
    bus.read_en_0 = '0; bus.rwarp_0 = '0; bus.raddr_0 = '0;
    bus.read_en_1 = '0; bus.rwarp_1 = '0; bus.raddr_1 = '0;
    bus.clr_req = 1'b0; bus.clr_warp = '0;
  endtask

  task automatic wr(input logic [WW-1:0] w, input logic [AW-1:0] a, input logic [LANES-1:0] m, input logic [VW-1:0] d);
    bus.wwarp = w; bus.waddr = a; bus.write_en = m; bus.wdata = d;
    tick;
    bus.write_en = '0;
  endtask

  task automatic rd(input logic [WW-1:0] w0, input logic [AW-1:0] a0, input logic [LANES-1:0] e0,
                    input logic [WW-1:0] w1, input logic [AW-1:0] a1, input logic [LANES-1:0] e1);
    bus.rwarp_0 = w0; bus.raddr_0 = a0; bus.read_en_0 = e0;
    bus.rwarp_1 = w1; bus.raddr_1 = a1; bus.read_en_1 = e1;
    tick;
    bus.read_en_0 = '0; bus.read_en_1 = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    checks++; if (bus.rdata_0 !== '0) begin failures++; $display("FAIL reset_rdata_0 got %h want 0", bus.rdata_0); end
    checks++; if (bus.rdata_1 !== '0) begin failures++; $display("FAIL reset_rdata_1 got %h want 0", bus.rdata_1); end
    checks++; if (bus.clr_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.clr_busy); end
    checks++; if (bus.clr_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.clr_done); end
    checks++; if (bus.wr_reject !== 1'b0) begin failures++; $display("FAIL reset_reject got %b want 0", bus.wr_reject); end
  endtask

  task automatic test_write_read;
    wr(3, 6'h2A, '1, vec(32'hA5000000, 1));
    wr(2, 6'h2A, '1, vec(32'h0BADF00D, 0));
    rd(3, 6'h2A, '1, 3, 6'h2A, '1);
    checks++; if (bus.rdata_0 !== vec(32'hA5000000, 1)) begin failures++; $display("FAIL wr_rd_p0 got %h want %h", bus.rdata_0, vec(32'hA5000000, 1)); end
    checks++; if (bus.rdata_1 !== vec(32'hA5000000, 1)) begin failures++; $display("FAIL wr_rd_p1 got %h want %h", bus.rdata_1, vec(32'hA5000000, 1)); end
    rd(2, 6'h2A, '1, 3, 6'h2A, '1);
    checks++; if (bus.rdata_0 !== vec(32'h0BADF00D, 0)) begin failures++; $display("FAIL warp_isolation got %h want %h", bus.rdata_0, vec(32'h0BADF00D, 0)); end
  endtask

  task automatic test_lane_mask;
    logic [VW-1:0] e;
    wr(3, 6'h10, '1, vec(32'h11111111, 0));
    wr(3, 6'h10, 16'h00F0, vec(32'h22222222, 0));
    rd(3, 6'h10, '1, 3, 6'h10, '1);
    e = vec(32'h11111111, 0);
    for (int i = 4; i < 8; i++) e[i*WIDTH +: WIDTH] = 32'h22222222;
    checks++; if (bus.rdata_0 !== e) begin failures++; $display("FAIL wmask_p0 got %h want %h", bus.rdata_0, e); end
    checks++; if (bus.rdata_1 !== e) begin failures++; $display("FAIL wmask_p1 got %h want %h", bus.rdata_1, e); end
    rd(3, 6'h2A, 16'h0001, 0, 0, '0);
    checks++; if (bus.rdata_1 !== e) begin failures++; $display("FAIL rmask_hold_p1 got %h want %h", bus.rdata_1, e); end
    e[WIDTH-1:0] = 32'hA5000000;
    checks++; if (bus.rdata_0 !== e) begin failures++; $display("FAIL rmask_p0 got %h want %h", bus.rdata_0, e); end
  endtask

  task automatic test_clear;
    int busy_n;
    for (int a = 0; a < REGS; a++) wr(5, AW'(a), '1, vec(32'h55000000 + WIDTH'(a << 8), 1));
    for (int a = 0; a < 4; a++) wr(4, AW'(a), '1, vec(32'h44000000 + WIDTH'(a << 8), 1));
    bus.clr_warp = 5; bus.clr_req = 1'b1;
    tick;
    bus.clr_req = 1'b0;
    busy_n = int'(bus.clr_busy);
    bus.wwarp = 5; bus.waddr = 6'd63; bus.write_en = '1; bus.wdata = '1;
    tick;
    bus.write_en = '0;
    busy_n += int'(bus.clr_busy);
    checks++; if (bus.wr_reject !== 1'b1) begin failures++; $display("FAIL reject_pulse got %b want 1", bus.wr_reject); end
    bus.wwarp = 1; bus.waddr = 6'd7; bus.write_en = '1; bus.wdata = vec(32'h12345678, 0);
    bus.clr_warp = 4; bus.clr_req = 1'b1;
    tick;
    bus.write_en = '0; bus.clr_req = 1'b0;
    busy_n += int'(bus.clr_busy);
    checks++; if (bus.wr_reject !== 1'b0) begin failures++; $display("FAIL reject_other_warp got %b want 0", bus.wr_reject); end
    for (int k = 0; k < 200 && bus.clr_busy; k++) begin
      tick;
      busy_n += int'(bus.clr_busy);
    end
    checks++; if (busy_n !== 64) begin failures++; $display("FAIL busy_cycles got %0d want 64", busy_n); end
    checks++; if (bus.clr_done !== 1'b1) begin failures++; $display("FAIL done_pulse got %b want 1", bus.clr_done); end
    tick;
    checks++; if (bus.clr_done !== 1'b0) begin failures++; $display("FAIL done_single got %b want 0", bus.clr_done); end
    checks++; if (bus.clr_busy !== 1'b0) begin failures++; $display("FAIL busy_after_done got %b want 0", bus.clr_busy); end
    for (int a = 0; a < REGS; a++) begin
      rd(5, AW'(a), '1, 4, AW'(a & 3), '1);
      checks++; if (bus.rdata_0 !== '0) begin failures++; $display("FAIL cleared_w5_a%0d got %h want 0", a, bus.rdata_0); end
      if (a < 4) begin
        checks++; if (bus.rdata_1 !== vec(32'h44000000 + WIDTH'(a << 8), 1)) begin failures++; $display("FAIL intact_w4_a%0d got %h want %h", a, bus.rdata_1, vec(32'h44000000 + WIDTH'(a << 8), 1)); end
      end
    end
    rd(1, 6'd7, '1, 0, 0, '0);
    checks++; if (bus.rdata_0 !== vec(32'h12345678, 0)) begin failures++; $display("FAIL parallel_write_w1 got %h want %h", bus.rdata_0, vec(32'h12345678, 0)); end
  endtask

  task automatic test_bypass;
    logic [VW-1:0] e;
    wr(0, 0, '1, vec(32'hC0C0C0C0, 0));
    bus.wwarp = 0; bus.waddr = 0; bus.write_en = '1; bus.wdata = vec(32'hDEADBEEF, 0);
    rd(0, 0, '1, 0, 0, '0);
    bus.write_en = '0;
`ifdef RBLOCK_BYPASS_EN
    e = vec(32'hDEADBEEF, 0);
`else
    e = vec(32'hC0C0C0C0, 0);
`endif
    checks++; if (bus.rdata_0 !== e) begin failures++; $display("FAIL same_cycle_rw got %h want %h", bus.rdata_0, e); end
    rd(0, 0, '1, 0, 0, '0);
    checks++; if (bus.rdata_0 !== vec(32'hDEADBEEF, 0)) begin failures++; $display("FAIL following_read got %h want %h", bus.rdata_0, vec(32'hDEADBEEF, 0)); end
  endtask

  task automatic test_reset_mid_clear;
    logic [VW-1:0] e;
    for (int a = 0; a < 16; a++) wr(7, AW'(a), '1, vec(32'h77000000 + WIDTH'(a << 8), 1));
    bus.clr_warp = 7; bus.clr_req = 1'b1;
    tick;
    bus.clr_req = 1'b0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    checks++; if (bus.clr_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b want 0", bus.clr_busy); end
    rst = 1'b0;
    tick;
    checks++; if (bus.clr_done !== 1'b0) begin failures++; $display("FAIL midrst_no_done got %b want 0", bus.clr_done); end
    for (int a = 0; a < 16; a++) begin
      rd(7, AW'(a), '1, 0, 0, '0);
      e = (a < 10) ? '0 : vec(32'h77000000 + WIDTH'(a << 8), 1);
      checks++; if (bus.rdata_0 !== e) begin failures++; $display("FAIL midrst_w7_a%0d got %h want %h", a, bus.rdata_0, e); end
    end
    bus.clr_warp = 7; bus.clr_req = 1'b1;
    tick;
    bus.clr_req = 1'b0;
    checks++; if (bus.clr_busy !== 1'b1) begin failures++; $display("FAIL reclear_accept got %b want 1", bus.clr_busy); end
    for (int k = 0; k < 200 && bus.clr_busy; k++) tick;
    checks++; if (bus.clr_done !== 1'b1) begin failures++; $display("FAIL reclear_done got %b want 1", bus.clr_done); end
  endtask

  initial begin
    idle;
    test_reset;
    test_write_read;
    test_lane_mask;
    test_clear;
    test_bypass;
    test_reset_mid_clear;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_block_mw.md
Name: register_block_mw

Overview:
- Parametrised next-generation warp register block for the SIMT core.
- Banked storage of WARPS x REGS x LANES words of WIDTH bits.
- Two read ports and one per-lane-masked write port, each with an independent warp select.
- Registered 1-cycle reads, plus a sequential warp-clear engine that zeroes one warp's whole context in the background.

Parameters:
- LANES, 16, number of SIMT lanes.
- REGS, 64, registers per warp per lane.
- WIDTH, 32, data bits per register.
- WARPS, 8, number of warp contexts.
- AW, $clog2(REGS), register address width (derived).
- WW, $clog2(WARPS), warp select width (derived).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- write_en  in  LANES  per-lane write enable.
- wwarp  in  WW  warp targeted by write.
- waddr  in  AW  write register address.
- wdata  in  LANES*WIDTH  write data; lane i at [i*WIDTH +: WIDTH].
- read_en_0  in  LANES  per-lane read enable, port 0.
- rwarp_0  in  WW  warp for port 0.
- raddr_0  in  AW  register address, port 0.
- read_en_1  in  LANES  per-lane read enable, port 1.
- rwarp_1  in  WW  warp for port 1.
- raddr_1  in  AW  register address, port 1.
- rdata_0  out  LANES*WIDTH  port 0 read data, registered.
- rdata_1  out  LANES*WIDTH  port 1 read data, registered.
- clr_req  in  1  start clearing warp clr_warp (single-cycle pulse).
- clr_warp  in  WW  warp to clear.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse at clear completion.
- wr_reject  out  1  one-cycle pulse: a write was dropped due to an active clear.

Behaviour:
- Reset (rst=1 at posedge):
  - rdata_0, rdata_1 = 0; clr_busy = 0; clr_done = 0; wr_reject = 0.
  - FSM goes to IDLE; clear pointer = 0.
  - Storage contents are not reset (undefined until written or cleared).
  - rst has priority over every other input in the same cycle.
- Write:
  - At posedge, lane i stores wdata lane i into [wwarp][waddr][i] when write_en[i]=1 and the write is accepted.
  - Lanes with write_en[i]=0 are unchanged.
- Read:
  - At posedge, lane i of rdata_p loads [rwarp_p][raddr_p][i] when read_en_p[i]=1.
  - Lanes with read_en_p[i]=0 hold their previous value.
  - Latency is 1 cycle: data is visible after the posedge that sampled the address.
  - Ports are fully independent; both may read the same location.
- Same-cycle read/write to the same warp, address and lane: controlled by RBLOCK_BYPASS_EN.
- Clear FSM:
  - IDLE: clr_req=1 latches clr_warp and resets ptr to 0 -> CLEAR.
  - CLEAR: each cycle writes 0 to all LANES of [latched warp][ptr], then ptr+1. clr_busy=1.
  - CLEAR exit: after ptr = REGS-1 is written -> DONE.
  - DONE: clr_done=1 for one cycle, clr_busy=0 -> IDLE.
  - A full clear takes REGS cycles in CLEAR plus 1 DONE cycle.
  - clr_req while in CLEAR or DONE is ignored; no queueing.
- Write collision with clear:
  - While clr_busy=1, any write with wwarp = latched clear warp and |write_en=1 is dropped entirely, and wr_reject pulses in the following cycle.
  - Writes to other warps proceed normally in parallel with the clear.
- Clear vs. reads: reads of the warp being cleared return the stored value; a not-yet-cleared address returns old data.
- Reset mid-clear: the clear aborts; the partially cleared warp keeps its mixed contents; clr_done is not pulsed.
- Width rules: the ptr is AW+1 bits internally so the terminal compare cannot wrap. Addresses are used unsigned; REGS need not be a power of two, and addresses >= REGS are ignored for writes and return 0 on reads.

Optional Feature:
- Macro: RBLOCK_BYPASS_EN.
- Defined: a read whose warp, address and lane match an accepted write in the same cycle loads the new wdata lane into rdata. A read of the location the clear engine writes this cycle loads 0.
- Undefined: the same-cycle read returns the pre-write stored value; new data appears on a read issued the next cycle or later.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> rdata_0 = rdata_1 = 0, clr_busy = 0, clr_done = 0, wr_reject = 0.
- Write/read, all lanes:
  - Stimulus: write_en=16'hFFFF, wwarp=3, waddr=6'h2A, lane i data = 32'hA5000000+i.
  - Next cycle, read both ports at warp 3, address 2A -> one cycle later both ports show A5000000+i in every lane.
  - Read warp 2, address 2A -> differs (warp isolation).
- Lane mask:
  - Stimulus: write 32'h11111111 to all lanes, then write_en=16'h00F0 with data 32'h22222222, same warp and address.
  - Read -> lanes 4-7 = 22222222, other lanes = 11111111.
  - read_en_0=16'h0001 -> only lane 0 of rdata_0 updates.
- Clear:
  - Stimulus: fill warp 5 with nonzero data, pulse clr_req with clr_warp=5.
  - Response: clr_busy high for exactly 64 cycles, then clr_done pulses once; all warp 5 reads return 0; warp 4 data intact.
  - Write to warp 5 while busy -> wr_reject pulses and data is not stored.
  - Write to warp 1 while busy -> succeeds.
- Bypass:
  - Stimulus: write 32'hDEADBEEF to warp 0, address 0, and read the same location in the same cycle.
  - With RBLOCK_BYPASS_EN: rdata = DEADBEEF next cycle.
  - Without RBLOCK_BYPASS_EN: old value next cycle; DEADBEEF on the following read.
- Reset mid-clear:
  - Stimulus: start a clear of warp 7, assert rst at ptr=10.
  - Response: clr_busy = 0, no clr_done; addresses 0-9 of warp 7 read 0; address 10 and above keep old data; a new clr_req is accepted afterwards.
